// File: rtl/synth_pkg.sv
// Shared definitions for the oscillator phase accumulator: slot geometry,
// sweep state encoding and the slot tag carried alongside each LUT address.
package synth_pkg;

    localparam int VOICES  = 8;
    localparam int V_OSC   = 4;
    localparam int V_WIDTH = 3;
    localparam int O_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [V_WIDTH-1:0] vx;
        logic [O_WIDTH-1:0] ox;
    } slot_t;

endpackage

// File: rtl/phase_slot_ram.sv
// Per-slot stored phase: register array with asynchronous clear, one
// combinational read port and one write port sharing the same address.
module phase_slot_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Clear every phase on reset; otherwise write back the updated phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/osc_phase_accum.sv
// Time-multiplexed phase accumulator: one sweep per frame_start visits every
// voice/oscillator slot, advances its phase by the fetched increment, adds
// the phase modulation (never stored) and issues the tagged sine LUT address.
module osc_phase_accum
    import synth_pkg::state_t, synth_pkg::slot_t,
           synth_pkg::IDLE, synth_pkg::SWEEP, synth_pkg::DRAIN;
#(
    parameter int VOICES    = 8,
    parameter int V_OSC     = 4,
    parameter int V_WIDTH   = 3,
    parameter int O_WIDTH   = 2,
    parameter int PH_WIDTH  = 32,
    parameter int MOD_SHIFT = 16,
    parameter int LUT_AW    = 11
) (
    input  logic                sCLK_XVXOSC,
    input  logic                reset_reg_N,
    input  logic                frame_start,
    input  logic                voice_sync,
    input  logic [V_WIDTH-1:0]  voice_sync_vx,
    output logic                slot_req,
    output logic [V_WIDTH-1:0]  slot_vx,
    output logic [O_WIDTH-1:0]  slot_ox,
    input  logic [PH_WIDTH-1:0] osc_inc,
    input  logic signed [10:0]  modulation,
    output logic                lut_valid,
    output logic [LUT_AW-1:0]   lut_addr,
    output logic [V_WIDTH-1:0]  lut_vx,
    output logic [O_WIDTH-1:0]  lut_ox,
    output logic                busy,
    output logic                overrun
);

    localparam int SLOT_W = V_WIDTH + O_WIDTH;
    localparam int SLOTS  = VOICES * V_OSC;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

    state_t              state;
    state_t              next_state;
    logic                accept;
    logic [SLOT_W-1:0]   slot_cnt;
    logic                drain_cnt;

    logic [VOICES-1:0]   pending;
    logic [VOICES-1:0]   active;
    logic [VOICES-1:0]   sync_req;

    logic                s1_valid;
    slot_t               s1_slot;
    logic [SLOT_W-1:0]   s1_addr;
    logic [PH_WIDTH-1:0] ph_rd;
    logic [PH_WIDTH-1:0] ph_new;
    logic [PH_WIDTH-1:0] mod_ext;
    logic [PH_WIDTH-1:0] pm;
    slot_t               lut_tag;

    assign slot_req = (state == SWEEP);
    assign slot_ox  = slot_cnt[O_WIDTH-1:0];
    assign slot_vx  = slot_cnt[SLOT_W-1:O_WIDTH];
    assign busy     = (state != IDLE);
    assign lut_vx   = lut_tag.vx;
    assign lut_ox   = lut_tag.ox;
    assign s1_addr  = {s1_slot.vx, s1_slot.ox};

    // Sweep state register.
    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a frame is accepted only from IDLE.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    next_state = SWEEP;
                    accept     = 1'b1;
                end
            end
            SWEEP: begin
                if (slot_cnt == LAST_SLOT) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Slot counter runs through all slots; drain counter spans two cycles.
    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            slot_cnt  <= '0;
            drain_cnt <= 1'b0;
        end else begin
            if (accept) begin
                slot_cnt <= '0;
            end else if (state == SWEEP) begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    // Decode the incoming sync strobe into a per-voice request vector.
    always_comb begin
        sync_req = '0;
        if (voice_sync) begin
            sync_req[voice_sync_vx] = 1'b1;
        end
    end

    // Latch sync requests; they take effect as a whole at the next frame.
    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            pending <= '0;
            active  <= '0;
        end else if (accept) begin
            active  <= pending | sync_req;
            pending <= '0;
        end else begin
            pending <= pending | sync_req;
        end
    end

    // Sticky flag for a frame_start that arrives while a sweep is running.
    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            overrun <= 1'b0;
        end else if (frame_start && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end

    // Delay the requested slot by one cycle to line up with osc_inc/modulation.
    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            s1_valid <= 1'b0;
            s1_slot  <= '0;
        end else begin
            s1_valid   <= slot_req;
            s1_slot.vx <= slot_vx;
            s1_slot.ox <= slot_ox;
        end
    end

    phase_slot_ram #(
        .DEPTH (SLOTS),
        .AW    (SLOT_W),
        .DW    (PH_WIDTH)
    ) u_ram (
        .clk   (sCLK_XVXOSC),
        .rst_n (reset_reg_N),
        .we    (s1_valid),
        .addr  (s1_addr),
        .wdata (ph_new),
        .rdata (ph_rd)
    );

    // Stage 1: phase advance (or sync to zero) and modulated LUT phase.
    always_comb begin
        ph_new  = active[s1_slot.vx] ? '0 : ph_rd + osc_inc;
        mod_ext = {{(PH_WIDTH-11){modulation[10]}}, modulation};
        pm      = ph_new + (mod_ext << MOD_SHIFT);
    end

    // Register LUT address and tag; they hold their last value between sweeps.
    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            lut_valid <= 1'b0;
            lut_addr  <= '0;
            lut_tag   <= '0;
        end else begin
            lut_valid <= s1_valid;
            if (s1_valid) begin
                lut_addr <= pm[PH_WIDTH-1 -: LUT_AW];
                lut_tag  <= s1_slot;
            end
        end
    end

endmodule

// File: tb/tb_osc_phase_accum.sv
// Scoreboard bench for osc_phase_accum: frames are issued with hand-computed
// expected LUT addresses pushed into a queue; a monitor pops and compares.
module tb_osc_phase_accum;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               frame_start = 1'b0;
    logic               voice_sync = 1'b0;
    logic [2:0]         voice_sync_vx = '0;
    logic [31:0]        osc_inc = '0;
    logic signed [10:0] modulation = '0;
    logic               slot_req;
    logic [2:0]         slot_vx;
    logic [1:0]         slot_ox;
    logic               lut_valid;
    logic [10:0]        lut_addr;
    logic [2:0]         lut_vx;
    logic [1:0]         lut_ox;
    logic               busy;
    logic               overrun;

    typedef struct packed {
        logic [10:0] addr;
        logic [2:0]  vx;
        logic [1:0]  ox;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails = 0;
    bit   monitor_en = 1'b0;

    osc_phase_accum dut (
        .sCLK_XVXOSC   (clk),
        .reset_reg_N   (rst_n),
        .frame_start   (frame_start),
        .voice_sync    (voice_sync),
        .voice_sync_vx (voice_sync_vx),
        .slot_req      (slot_req),
        .slot_vx       (slot_vx),
        .slot_ox       (slot_ox),
        .osc_inc       (osc_inc),
        .modulation    (modulation),
        .lut_valid     (lut_valid),
        .lut_addr      (lut_addr),
        .lut_vx        (lut_vx),
        .lut_ox        (lut_ox),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_slot_req"},  32'(slot_req), 32'd0);
        checkOutput({tag, "_slot_tag"},  32'({slot_vx, slot_ox}), 32'd0);
        checkOutput({tag, "_lut_valid"}, 32'(lut_valid), 32'd0);
        checkOutput({tag, "_lut_addr"},  32'(lut_addr), 32'd0);
        checkOutput({tag, "_lut_tag"},   32'({lut_vx, lut_ox}), 32'd0);
        checkOutput({tag, "_busy"},      32'(busy), 32'd0);
        checkOutput({tag, "_overrun"},   32'(overrun), 32'd0);
    endtask

    // Monitor: every valid LUT output is matched against the oldest expectation.
    always @(negedge clk) begin
        if (monitor_en && lut_valid) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_lut_output: got addr 0x%0h tag %0d/%0d, expected none",
                         lut_addr, lut_vx, lut_ox);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("lut_addr", 32'(lut_addr), 32'(mon_e.addr));
                checkOutput("lut_tag", 32'({lut_vx, lut_ox}), 32'({mon_e.vx, mon_e.ox}));
            end
        end
    end

    // One full frame: called at cycle 0 (1 time unit after an edge), returns in cycle 35.
    task automatic applyStimulus(input logic [31:0] inc, input logic signed [10:0] mod,
                                 input logic [10:0] normal, input logic [10:0] synced,
                                 input logic [7:0] mask, input bit do_sync,
                                 input logic [2:0] sync_vx, input bit do_ovr);
        exp_t e;
        int   req_cnt;
        for (int n = 0; n < 32; n++) begin
            e.vx   = 3'(n >> 2);
            e.ox   = 2'(n & 3);
            e.addr = mask[e.vx] ? synced : normal;
            sb.push_back(e);
        end
        osc_inc     = inc;
        modulation  = mod;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        req_cnt = 0;
        for (int c = 1; c <= 34; c++) begin
            if (slot_req) req_cnt++;
            if (c == 2)  checkOutput("lut_valid_c2", 32'(lut_valid), 32'd0);
            if (c == 3)  checkOutput("lut_valid_c3", 32'(lut_valid), 32'd1);
            if (c == 34) checkOutput("busy_c34", 32'(busy), 32'd1);
            if (do_ovr && c == 11) checkOutput("overrun_set", 32'(overrun), 32'd1);
            if (do_sync && c == 5) begin
                voice_sync    = 1'b1;
                voice_sync_vx = sync_vx;
            end
            if (do_ovr && c == 10) frame_start = 1'b1;
            @(posedge clk);
            #1;
            voice_sync  = 1'b0;
            frame_start = 1'b0;
        end
        checkOutput("slot_req_count", 32'(req_cnt), 32'd32);
        checkOutput("busy_c35", 32'(busy), 32'd0);
        checkOutput("lut_valid_c35", 32'(lut_valid), 32'd0);
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #1;
        checkResetOutputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        checkResetOutputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Frame aborted by an asynchronous reset in cycle 10.
        osc_inc     = 32'h0100_0000;
        modulation  = '0;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("mid_sweep");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        monitor_en = 1'b1;

        // Increment only, starting from cleared phases.
        applyStimulus(32'h0100_0000, 11'sd0, 11'h008, 11'h000, 8'h00, 1'b0, 3'd0, 1'b0);
        applyStimulus(32'h0100_0000, 11'sd0, 11'h010, 11'h000, 8'h00, 1'b0, 3'd0, 1'b0);

        // Modulation is applied to the output only, never stored.
        doReset("pre_mod");
        applyStimulus(32'h0, 11'sd32,  11'h001, 11'h000, 8'h00, 1'b0, 3'd0, 1'b0);
        applyStimulus(32'h0, -11'sd32, 11'h7FF, 11'h000, 8'h00, 1'b0, 3'd0, 1'b0);
        applyStimulus(32'h0, 11'sd0,   11'h000, 11'h000, 8'h00, 1'b0, 3'd0, 1'b0);

        // Half-turn increment wraps the stored phase every other frame.
        applyStimulus(32'h8000_0000, 11'sd0, 11'h400, 11'h000, 8'h00, 1'b0, 3'd0, 1'b0);
        applyStimulus(32'h8000_0000, 11'sd0, 11'h000, 11'h000, 8'h00, 1'b0, 3'd0, 1'b0);
        applyStimulus(32'h8000_0000, 11'sd0, 11'h400, 11'h000, 8'h00, 1'b0, 3'd0, 1'b0);

        // Sync of voice 3 requested mid-frame lands on the following frame.
        doReset("pre_sync");
        applyStimulus(32'h0100_0000, 11'sd0, 11'h008, 11'h000, 8'h00, 1'b1, 3'd3, 1'b0);
        applyStimulus(32'h0100_0000, 11'sd0, 11'h010, 11'h000, 8'h08, 1'b0, 3'd0, 1'b0);

        // Overrun during a sweep, then a back-to-back frame at cycle 35.
        applyStimulus(32'h0100_0000, 11'sd0, 11'h018, 11'h008, 8'h08, 1'b0, 3'd0, 1'b1);
        applyStimulus(32'h0100_0000, 11'sd0, 11'h020, 11'h010, 8'h08, 1'b0, 3'd0, 1'b0);
        checkOutput("overrun_sticky", 32'(overrun), 32'd1);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        monitor_en = 1'b0;
        doReset("final");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
